// File: rtl/status_flag_reg_pkg.sv
// Shared encodings for the status-flag register: ALU opcodes, flag bit
// positions inside {N,Z,C,V}, and branch condition codes.
package status_flag_reg_pkg;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b011,
        ALU_XOR = 3'b100,
        ALU_NOT = 3'b101,
        ALU_SHL = 3'b110,
        ALU_SHR = 3'b111
    } aluop_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [2:0] {
        COND_AL = 3'b000,
        COND_EQ = 3'b001,
        COND_NE = 3'b010,
        COND_CS = 3'b011,
        COND_CC = 3'b100,
        COND_MI = 3'b101,
        COND_VS = 3'b110,
        COND_LT = 3'b111
    } cond_e;

endpackage

// File: rtl/status_flag_reg_cond_eval.sv
// Combinational branch-condition decode over the live {N,Z,C,V} flags.
module cond_eval
    import status_flag_reg_pkg::*;
(
    input  logic [3:0] flags,
    input  logic [2:0] cond,
    output logic       hit
);

    always_comb begin
        hit = 1'b0;
        case (cond_e'(cond))
            COND_AL: hit = 1'b1;
            COND_EQ: hit = flags[FLAG_Z];
            COND_NE: hit = ~flags[FLAG_Z];
            COND_CS: hit = flags[FLAG_C];
            COND_CC: hit = ~flags[FLAG_C];
            COND_MI: hit = flags[FLAG_N];
            COND_VS: hit = flags[FLAG_V];
            COND_LT: hit = flags[FLAG_N] ^ flags[FLAG_V];
            default: hit = 1'b0;
        endcase
    end

endmodule

// File: rtl/status_flag_reg.sv
// Processor status-flag register: live N/Z/C/V, one-deep interrupt shadow,
// and a registered branch-condition evaluator.
module status_flag_reg
    import status_flag_reg_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flag_we,
    input  logic [2:0]       ALUop,
    input  logic             c_in,
    input  logic [WIDTH-1:0] result,
    input  logic             a_msb,
    input  logic             b_msb,
    input  logic             save,
    input  logic             restore,
    input  logic [2:0]       cond,
    input  logic             cond_req,
    output logic [3:0]       flags,
    output logic             shadow_valid,
    output logic             restore_err,
    output logic             cond_true,
    output logic             cond_valid
);

    logic [3:0] shadow;
    logic [3:0] alu_flags_p0;
    logic       cond_hit_p0;
    logic       do_restore;

    function automatic logic [3:0] next_alu_flags(
        input logic [3:0]       cur,
        input logic [2:0]       op,
        input logic [WIDTH-1:0] res,
        input logic             cin,
        input logic             am,
        input logic             bm
    );
        logic [3:0] f;
        logic       msb;
        f         = cur;
        msb       = res[WIDTH-1];
        f[FLAG_N] = msb;
        f[FLAG_Z] = (res == '0);
        case (aluop_e'(op))
            ALU_ADD: begin
                f[FLAG_C] = cin;
                f[FLAG_V] = (am == bm) && (msb != am);
            end
            ALU_SUB: begin
                f[FLAG_C] = cin;
                f[FLAG_V] = (am != bm) && (msb != am);
            end
            default: ;
        endcase
        return f;
    endfunction

    assign alu_flags_p0 = next_alu_flags(flags, ALUop, result, c_in, a_msb, b_msb);
    assign do_restore   = restore && shadow_valid;

    cond_eval u_cond_eval (
        .flags (flags),
        .cond  (cond),
        .hit   (cond_hit_p0)
    );

    // p0 -> registered state: restore outranks flag_we; save always sees old flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags        <= 4'b0000;
            shadow       <= 4'b0000;
            shadow_valid <= 1'b0;
            restore_err  <= 1'b0;
            cond_true    <= 1'b0;
            cond_valid   <= 1'b0;
        end else begin
            if (do_restore) begin
                flags <= shadow;
            end else if (flag_we && !restore) begin
                flags <= alu_flags_p0;
            end

            if (save) begin
                shadow       <= flags;
                shadow_valid <= 1'b1;
            end else if (do_restore) begin
                shadow_valid <= 1'b0;
            end

            restore_err <= restore && !shadow_valid;
            cond_valid  <= cond_req;
            if (cond_req) begin
                cond_true <= cond_hit_p0;
            end
        end
    end

endmodule
